// File: rtl/wrsync_level.sv
// wrsync_level: brings the read Gray pointer into the write clock domain and
// derives registered fill level, almost-full, sticky overflow and level-error flags.
`default_nettype none

module wrsync_level #(
  parameter int address_size = 3,
  parameter int sync_stages  = 2
) (
  input  logic                    write_clk_i,
  input  logic                    write_reset_n_i,
  input  logic [address_size:0]   read_pointer_i,
  input  logic [address_size:0]   write_pointer_i,
  input  logic                    write_increment_i,
  input  logic                    write_full_i,
  input  logic [address_size:0]   almost_full_threshold_i,
  input  logic                    overflow_clear_i,
  output logic [address_size:0]   read_to_write_pointer_o,
  output logic [address_size:0]   write_level_o,
  output logic                    write_almost_full_o,
  output logic                    write_overflow_o,
  output logic                    write_level_error_o
);

  localparam logic [address_size:0] DEPTH = (address_size + 1)'(1) << address_size;

  logic [address_size:0] sync_ff [sync_stages];
  logic [address_size:0] read_bin;
  logic [address_size:0] write_bin;
  logic [address_size:0] level_next;

  function automatic logic [address_size:0] gray2bin(input logic [address_size:0] g);
    logic [address_size:0] b;
    b[address_size] = g[address_size];
    for (int i = address_size - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // First stage samples the asynchronous pointer; later stages only shift.
  always_ff @(posedge write_clk_i or negedge write_reset_n_i) begin
    if (!write_reset_n_i) begin
      sync_ff[0] <= '0;
    end else begin
      sync_ff[0] <= read_pointer_i;
    end
  end

  generate
    for (genvar s = 1; s < sync_stages; s++) begin : g_sync
      always_ff @(posedge write_clk_i or negedge write_reset_n_i) begin
        if (!write_reset_n_i) begin
          sync_ff[s] <= '0;
        end else begin
          sync_ff[s] <= sync_ff[s-1];
        end
      end
    end
  endgenerate

  assign read_to_write_pointer_o = sync_ff[sync_stages-1];

  always_comb begin
    read_bin   = gray2bin(read_to_write_pointer_o);
    write_bin  = gray2bin(write_pointer_i);
    level_next = write_bin - read_bin;
  end

  // Overflow set takes priority over a same-cycle clear.
  always_ff @(posedge write_clk_i or negedge write_reset_n_i) begin
    if (!write_reset_n_i) begin
      write_level_o       <= '0;
      write_almost_full_o <= 1'b0;
      write_overflow_o    <= 1'b0;
      write_level_error_o <= 1'b0;
    end else begin
      write_level_o       <= level_next;
      write_almost_full_o <= (level_next >= almost_full_threshold_i);
      if (write_increment_i && write_full_i) begin
        write_overflow_o <= 1'b1;
      end else if (overflow_clear_i) begin
        write_overflow_o <= 1'b0;
      end
      if (level_next > DEPTH) begin
        write_level_error_o <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wrsync_level.sv
// Randomised and directed self-checking bench for wrsync_level (A=3, 2 sync stages).
`default_nettype none

module tb_wrsync_level;
  localparam int A = 3;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [A:0] rp = '0, wp = '0, thr = '0;
  logic       inc = 1'b0, full = 1'b0, clr = 1'b0;
  logic [A:0] sync_out, level;
  logic       af, ovf, err;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [A:0] m_q[$];
  int         m_level;
  bit         m_af, m_ovf, m_err;

  always #5 clk = ~clk;

  wrsync_level #(.address_size(A), .sync_stages(S)) dut (
    .write_clk_i             (clk),
    .write_reset_n_i         (rst_n),
    .read_pointer_i          (rp),
    .write_pointer_i         (wp),
    .write_increment_i       (inc),
    .write_full_i            (full),
    .almost_full_threshold_i (thr),
    .overflow_clear_i        (clr),
    .read_to_write_pointer_o (sync_out),
    .write_level_o           (level),
    .write_almost_full_o     (af),
    .write_overflow_o        (ovf),
    .write_level_error_o     (err)
  );

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int g2b(input int g);
    int b = 0;
    for (int s = 0; s <= A; s++) b = b ^ (g >> s);
    return b & ((1 << (A + 1)) - 1);
  endfunction

  function automatic logic [A:0] b2g(input int b);
    int m = b & ((1 << (A + 1)) - 1);
    return (A + 1)'(m ^ (m >> 1));
  endfunction

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < S; i++) m_q.push_back('0);
    m_level = 0; m_af = 0; m_ovf = 0; m_err = 0;
  endtask

  task automatic check_all();
    check("sync", int'(sync_out), int'(m_q[0]));
    check("level", int'(level), m_level);
    check("almost_full", int'(af), int'(m_af));
    check("overflow", int'(ovf), int'(m_ovf));
    check("level_error", int'(err), int'(m_err));
  endtask

  // One clock: model consumes the pre-edge inputs, then outputs are compared.
  task automatic step();
    int lvl;
    @(posedge clk);
    lvl = (g2b(int'(wp)) - g2b(int'(m_q[0]))) % (1 << (A + 1));
    if (lvl < 0) lvl += (1 << (A + 1));
    m_level = lvl;
    m_af    = (lvl >= int'(thr));
    if (lvl > (1 << A)) m_err = 1;
    if (inc && full) m_ovf = 1;
    else if (clr)    m_ovf = 0;
    void'(m_q.pop_front());
    m_q.push_back(rp);
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Assert reset between edges and check the outputs clear without a clock.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int rbin, wbin;
    model_reset();

    // Reset with a non-zero read pointer present
    rp = 4'b0101;
    steps(3);
    do_reset();
    step();
    check("rst_sync_hold", int'(sync_out), 0);
    check("rst_level_hold", int'(level), 0);
    step();

    // Fill 1..8 with threshold 6
    rp = '0; wp = '0; thr = 4'd6;
    do_reset();
    steps(S + 1);
    for (int b = 1; b <= 8; b++) begin
      wp = b2g(b);
      step();
      check("fill_level", int'(level), b);
      check("fill_af", int'(af), int'(b >= 6));
    end
    check("fill_err", int'(err), 0);

    // Sync latency
    wp = 4'b0110; rp = 4'b0000;
    steps(S + 1);
    rp = 4'b0001;
    step();
    check("lat_sync1", int'(sync_out), 0);
    step();
    check("lat_sync2", int'(sync_out), 1);
    check("lat_level_old", int'(level), 4);
    step();
    check("lat_level_new", int'(level), 3);

    // Wrap-around
    wp = 4'b0001; rp = 4'b1010;
    steps(S + 2);
    check("wrap_level5", int'(level), 5);
    wp = 4'b1010;
    step();
    check("wrap_level0", int'(level), 0);

    // Overflow set / set-beats-clear / clear
    inc = 1; full = 1;
    step();
    check("ovf_set", int'(ovf), 1);
    clr = 1;
    step();
    check("ovf_set_wins", int'(ovf), 1);
    inc = 0; full = 0;
    step();
    check("ovf_clear", int'(ovf), 0);
    clr = 0;

    // Threshold extremes
    thr = 4'd0;
    step();
    check("thr0_af", int'(af), 1);
    wp = b2g(g2b(int'(rp)) + 8);
    thr = 4'd9;
    steps(2);
    check("thr9_af", int'(af), 0);
    check("full_level8", int'(level), 8);

    // Randomised traffic with one-step Gray moves on the read pointer
    do_reset();
    rbin = 0; wbin = 0; rp = '0; wp = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0 && (wbin - rbin) < 8) wbin++;
      if ($urandom_range(0, 2) != 0 && rbin < wbin) rbin++;
      wp   = b2g(wbin);
      rp   = b2g(rbin);
      inc  = 1'($urandom);
      full = 1'($urandom_range(0, 3) == 0);
      clr  = 1'($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) thr = 4'($urandom_range(0, 15));
      step();
    end
    inc = 0; full = 0; clr = 0;

    // Pointer corruption, sticky after restore
    do_reset();
    wp = 4'b1111; rp = 4'b0000;
    steps(S + 2);
    check("corrupt_level", int'(level), 10);
    check("corrupt_err", int'(err), 1);
    wp = 4'b0000;
    steps(S + 2);
    check("corrupt_sticky", int'(err), 1);
    check("corrupt_restored_level", int'(level), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
